pid_dac_conditioner: RTL and testbench
======================================

Name: pid_dac_conditioner

Overview:
- Downstream stage of the PID controller. Consumes the 32-bit signed control output and its valid strobe.
- Scales the value by an arithmetic right shift, clamps it to programmable limits, then applies a per-update slew limit.
- Streams the resulting 16-bit actuator command to an external SPI DAC as an offset-binary word.
- Sits between the PID Wishbone slave and the board-level DAC pins.

Parameters:
- SHIFT, 8, arithmetic right-shift applied to i_un (matches PID fixed-point format).
- RATE_MAX, 256, max |change| of o_cmd per accepted sample (positive, < 2^15).
- CLK_DIV, 4, clk cycles per SPI sclk half-period (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_un  in  32  signed PID output
- i_valid  in  1  one-cycle strobe, i_un valid
- i_enable  in  1  when low, i_valid is ignored
- i_min  in  16  signed lower clamp
- i_max  in  16  signed upper clamp
- o_cmd  out  16  signed current command
- o_cmd_valid  out  1  one-cycle pulse when o_cmd updates
- o_sat  out  1  last sample was clamped
- o_rate_lim  out  1  last sample was slew-limited
- o_busy  out  1  SPI transfer in progress or pending
- o_drop_cnt  out  8  pending-buffer overwrites, saturates at 255
- spi_cs_n  out  1  DAC chip select, active low
- spi_sclk  out  1  SPI clock, mode 0
- spi_mosi  out  1  SPI data, MSB first

Behaviour:
- Reset (rst low, asynchronous): o_cmd=0, o_cmd_valid=0, o_sat=0, o_rate_lim=0, o_busy=0, o_drop_cnt=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, pending flag cleared, FSM=IDLE. Assertion mid-transfer aborts the transfer immediately.
- Accept: i_valid & i_enable at edge N.
- Stage 1 (edge N+1):
  - s = i_un >>> SHIFT, sign-preserving, kept at 32 bits.
  - If s < i_min, c = i_min; else if s > i_max, c = i_max; else c = s[15:0].
  - sat = clamped.
  - If i_min > i_max, the upper check wins and c = i_max.
- Stage 2 (edge N+2):
  - d = c - o_cmd, computed in 17 bits.
  - If d > RATE_MAX, o_cmd += RATE_MAX; if d < -RATE_MAX, o_cmd -= RATE_MAX; else o_cmd = c.
  - o_rate_lim = limited; o_sat registered alongside.
  - o_cmd_valid pulses at N+2. Latency from i_valid to o_cmd_valid is 2 cycles; one sample per cycle is accepted.
- DAC word: w = o_cmd ^ 16'h8000 (offset binary).
- SPI FSM, states IDLE, LOAD, HIGH, LOW, GAP:
  - IDLE: on o_cmd_valid or pending, latch w, clear pending, go to LOAD.
  - LOAD: cs_n=0, mosi=w[15], sclk=0 for CLK_DIV cycles.
  - HIGH: sclk=1 for CLK_DIV cycles.
  - LOW: sclk=0 for CLK_DIV cycles. Mosi moves to the next bit on entry to LOW. After bit 0's LOW phase go to GAP; otherwise go to HIGH.
  - GAP: cs_n=1, sclk=0, mosi=0 for CLK_DIV cycles, then IDLE.
  - cs_n is low for 33*CLK_DIV cycles (132 at default), giving 16 rising sclk edges.
- Pending buffer, one-deep:
  - If o_cmd_valid arrives while FSM != IDLE, store w and set pending.
  - If pending is already set, overwrite it and increment o_drop_cnt (saturating).
  - If o_cmd_valid and the GAP->IDLE exit coincide, the new word goes to pending and starts next cycle, with no drop.
- o_busy = (FSM != IDLE) | pending.
- i_enable low: new samples are ignored. An in-flight transfer and a pending word still complete. o_cmd holds.

Decomposition:
- Shared package pid_io_pkg: SPI FSM state enum (IDLE, LOAD, HIGH, LOW, GAP), DAC_W=16, OFFSET_BIN=16'h8000.
- One sub-module, spi_dac_tx: FSM, bit counter, clock divider and shifter, with a start/word/busy interface.
- Scale, clamp, slew limit and the pending buffer stay in the top level.

Test Plan:
- Reset with i_min=-32768, i_max=32767, then i_un=32'h00012345 with i_valid:
  - At N+2: o_cmd=16'h0100 (slew-limited from 291), o_rate_lim=1, o_sat=0.
  - SPI shifts 16'h8100, MSB first, 16 rising edges, cs_n low for 132 cycles.
- Same limits, repeat i_un=32'h00012345 after the first transfer: o_cmd=16'h0123, o_rate_lim=0, DAC word 16'h8123.
- i_max=16'h1000, RATE_MAX large via override, i_un=32'h7FFFFFFF: o_cmd=16'h1000, o_sat=1, DAC word 16'h9000.
- i_un=32'hFFFF0000 from o_cmd=0: s=-256, o_cmd=16'hFF00, DAC word 16'h7F00.
- Three i_valid strobes 3 cycles apart during one transfer:
  - o_drop_cnt=1.
  - Exactly two transfers occur, the second carrying the third sample.
  - o_busy falls only after the second GAP.
- rst low at cycle 40 of a transfer: within the same edge spi_cs_n=1, sclk=0, o_cmd=0, o_busy=0. No further sclk edges until a new i_valid.

Source files
------------

// File: rtl/pid_io_pkg.sv
// Shared types and constants for the PID output stage and its SPI DAC link.
package pid_io_pkg;

    localparam int               DAC_W      = 16;
    localparam logic [DAC_W-1:0] OFFSET_BIN = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HIGH,
        LOW,
        GAP
    } spi_state_e;

endpackage

// File: rtl/pid_dac_conditioner_spi.sv
// Mode-0 SPI transmitter for a 16-bit DAC word, MSB first, with a
// chip-select gap after each frame.
module spi_dac_tx
    import pid_io_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DAC_W-1:0] word_i,
    output logic             busy_o,
    output logic             spi_cs_n_o,
    output logic             spi_sclk_o,
    output logic             spi_mosi_o
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    spi_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bits_q, bits_d;
    logic [DAC_W-1:0] shreg_q, shreg_d;
    logic             phase_end;
    logic             frame_active;

    assign phase_end    = (div_q == DIV_LAST);
    assign frame_active = (state_q == LOAD) || (state_q == HIGH) || (state_q == LOW);

    // Next-state logic: every non-idle phase lasts CLK_DIV cycles; bits_q counts
    // the rising sclk phases still to come, and the word shifts on entry to LOW.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        if (state_q != IDLE) begin
            div_d = phase_end ? '0 : div_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    shreg_d = word_i;
                    bits_d  = 5'd16;
                    div_d   = '0;
                end
            end
            LOAD: begin
                if (phase_end) state_d = HIGH;
            end
            HIGH: begin
                if (phase_end) begin
                    state_d = LOW;
                    shreg_d = {shreg_q[DAC_W-2:0], 1'b0};
                    bits_d  = bits_q - 1'b1;
                end
            end
            LOW: begin
                if (phase_end) state_d = (bits_q == 5'd0) ? GAP : HIGH;
            end
            GAP: begin
                if (phase_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bits_q  <= bits_d;
        end
    end

    // Shift register holds data only; its content matters only inside a frame.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign busy_o     = (state_q != IDLE);
    assign spi_cs_n_o = !frame_active;
    assign spi_sclk_o = (state_q == HIGH);
    assign spi_mosi_o = frame_active & shreg_q[DAC_W-1];

endmodule

// File: rtl/pid_dac_conditioner.sv
// Scales, clamps and slew-limits the PID output, then streams it to an SPI DAC
// through a one-deep pending buffer.
module pid_dac_conditioner
    import pid_io_pkg::*;
#(
    parameter int SHIFT    = 8,
    parameter int RATE_MAX = 256,
    parameter int CLK_DIV  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [31:0]      i_un,
    input  logic                    i_valid,
    input  logic                    i_enable,
    input  logic signed [DAC_W-1:0] i_min,
    input  logic signed [DAC_W-1:0] i_max,
    output logic signed [DAC_W-1:0] o_cmd,
    output logic                    o_cmd_valid,
    output logic                    o_sat,
    output logic                    o_rate_lim,
    output logic                    o_busy,
    output logic [7:0]              o_drop_cnt,
    output logic                    spi_cs_n,
    output logic                    spi_sclk,
    output logic                    spi_mosi
);

    localparam logic signed [DAC_W:0] RATE_X = (DAC_W+1)'(RATE_MAX);

    // Clamp to [mn, mx]; with inverted limits the upper bound wins outright.
    // Returns {clamped, value}.
    function automatic logic [DAC_W:0] clamp_fn(input logic signed [31:0]      s,
                                                input logic signed [DAC_W-1:0] mn,
                                                input logic signed [DAC_W-1:0] mx);
        if (mn > mx || s > mx) return {1'b1, mx};
        if (s < mn)            return {1'b1, mn};
        return {1'b0, s[DAC_W-1:0]};
    endfunction

    // Move cur toward tgt by at most RATE_MAX. Returns {limited, value}.
    function automatic logic [DAC_W:0] slew_fn(input logic signed [DAC_W-1:0] tgt,
                                               input logic signed [DAC_W-1:0] cur);
        logic signed [DAC_W:0] tgt_x;
        logic signed [DAC_W:0] cur_x;
        logic signed [DAC_W:0] diff;
        logic signed [DAC_W:0] nxt;
        tgt_x = {tgt[DAC_W-1], tgt};
        cur_x = {cur[DAC_W-1], cur};
        diff  = tgt_x - cur_x;
        if (diff > RATE_X) begin
            nxt = cur_x + RATE_X;
            return {1'b1, nxt[DAC_W-1:0]};
        end
        if (diff < -RATE_X) begin
            nxt = cur_x - RATE_X;
            return {1'b1, nxt[DAC_W-1:0]};
        end
        return {1'b0, tgt};
    endfunction

    logic                    accept_p0;
    logic signed [31:0]      s_p0;
    logic signed [DAC_W-1:0] cmd_p1_d, cmd_p1_q;
    logic                    sat_p1_d, sat_p1_q;
    logic                    vld_p1_q;
    logic signed [DAC_W-1:0] cmd_p2_d, cmd_p2_q;
    logic                    rl_p2_d, rl_p2_q;
    logic                    sat_p2_q;
    logic                    vld_p2_q;
    logic [DAC_W-1:0]        w_p2;
    logic                    pend_d, pend_q;
    logic [DAC_W-1:0]        pend_word_d, pend_word_q;
    logic [7:0]              drop_d, drop_q;
    logic                    tx_busy;
    logic                    tx_start;
    logic [DAC_W-1:0]        tx_word;

    assign accept_p0            = i_valid & i_enable;
    assign s_p0                 = i_un >>> SHIFT;
    assign {sat_p1_d, cmd_p1_d} = clamp_fn(s_p0, i_min, i_max);
    assign {rl_p2_d, cmd_p2_d}  = slew_fn(cmd_p1_q, cmd_p2_q);

    // ---- stage 0 -> 1: scale and clamp ----
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            cmd_p1_q <= cmd_p1_d;
            sat_p1_q <= sat_p1_d;
        end
    end

    // Pipeline control and the actuator command, which must come up at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            cmd_p2_q <= '0;
            rl_p2_q  <= 1'b0;
            sat_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= accept_p0;
            // ---- stage 1 -> 2: slew limit against the current command ----
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                cmd_p2_q <= cmd_p2_d;
                rl_p2_q  <= rl_p2_d;
                sat_p2_q <= sat_p1_q;
            end
        end
    end

    // DAC handoff: a fresh word starts immediately when the transmitter is idle,
    // otherwise it parks in the pending slot, displacing (and counting) any older one.
    assign w_p2     = cmd_p2_q ^ OFFSET_BIN;
    assign tx_start = !tx_busy && (vld_p2_q || pend_q);
    assign tx_word  = vld_p2_q ? w_p2 : pend_word_q;

    // Pending-slot next state and drop accounting.
    always_comb begin
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        drop_d      = drop_q;
        if (vld_p2_q && tx_busy) begin
            pend_d      = 1'b1;
            pend_word_d = w_p2;
            if (pend_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end else if (tx_start) begin
            pend_d = 1'b0;
            if (vld_p2_q && pend_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    // Pending flag and drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
            drop_q <= '0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    // Pending word is data; it is only read while the flag is set.
    always_ff @(posedge clk) begin
        pend_word_q <= pend_word_d;
    end

    spi_dac_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .start_i    (tx_start),
        .word_i     (tx_word),
        .busy_o     (tx_busy),
        .spi_cs_n_o (spi_cs_n),
        .spi_sclk_o (spi_sclk),
        .spi_mosi_o (spi_mosi)
    );

    assign o_cmd       = cmd_p2_q;
    assign o_cmd_valid = vld_p2_q;
    assign o_sat       = sat_p2_q;
    assign o_rate_lim  = rl_p2_q;
    assign o_busy      = tx_busy | pend_q;
    assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_pid_dac_conditioner.sv
// Self-checking bench for pid_dac_conditioner: directed cases plus randomized
// samples against an arithmetic reference model and an SPI frame decoder.
`timescale 1ns/1ps
module tb_pid_dac_conditioner;

    localparam int SHIFT    = 8;
    localparam int RATE_MAX = 256;
    localparam int CLK_DIV  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        i_un;
    logic               i_valid;
    logic               i_enable;
    logic signed [15:0] i_min;
    logic signed [15:0] i_max;
    logic [15:0]        o_cmd;
    logic               o_cmd_valid;
    logic               o_sat;
    logic               o_rate_lim;
    logic               o_busy;
    logic [7:0]         o_drop_cnt;
    logic               spi_cs_n;
    logic               spi_sclk;
    logic               spi_mosi;

    pid_dac_conditioner #(
        .SHIFT    (SHIFT),
        .RATE_MAX (RATE_MAX),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_un        (i_un),
        .i_valid     (i_valid),
        .i_enable    (i_enable),
        .i_min       (i_min),
        .i_max       (i_max),
        .o_cmd       (o_cmd),
        .o_cmd_valid (o_cmd_valid),
        .o_sat       (o_sat),
        .o_rate_lim  (o_rate_lim),
        .o_busy      (o_busy),
        .o_drop_cnt  (o_drop_cnt),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] u16(input int v);
        return v[15:0];
    endfunction

    // Reference model state: current command and expected drop count.
    int m_cmd  = 0;
    int m_drop = 0;

    // Floor division by 2^SHIFT on the true signed value.
    function automatic int scale_floor(input logic [31:0] un);
        longint v, p, r;
        v = longint'($signed(un));
        p = longint'(1) << SHIFT;
        r = ((v % p) + p) % p;
        return int'((v - r) / p);
    endfunction

    task automatic model_step(input logic [31:0] un, output int sat, output int rl);
        int s, c, mn, mx, d;
        s  = scale_floor(un);
        mn = i_min;
        mx = i_max;
        if (mn > mx)     begin c = mx; sat = 1; end
        else if (s > mx) begin c = mx; sat = 1; end
        else if (s < mn) begin c = mn; sat = 1; end
        else             begin c = s;  sat = 0; end
        d = c - m_cmd;
        if (d > RATE_MAX)       begin m_cmd = m_cmd + RATE_MAX; rl = 1; end
        else if (d < -RATE_MAX) begin m_cmd = m_cmd - RATE_MAX; rl = 1; end
        else                    begin m_cmd = c;                rl = 0; end
    endtask

    function automatic logic [15:0] dac_word(input int cmd);
        return u16(cmd + 32768);
    endfunction

    // SPI frame decoder: samples mosi on each rising sclk, counts cs_n-low cycles.
    logic [15:0] mon_word_q[$];
    int          mon_edges_q[$];
    int          mon_low_q[$];
    int          total_rise = 0;
    bit          mon_in = 0;
    bit          mon_prev_sclk = 0;
    logic [15:0] mon_word;
    int          mon_low;
    int          mon_edges;

    always @(negedge clk) begin
        if (!rst) begin
            mon_in        = 0;
            mon_prev_sclk = 0;
        end else begin
            if (spi_sclk && !mon_prev_sclk) total_rise++;
            if (!spi_cs_n) begin
                if (!mon_in) begin
                    mon_in    = 1;
                    mon_low   = 0;
                    mon_edges = 0;
                    mon_word  = '0;
                end
                mon_low++;
                if (spi_sclk && !mon_prev_sclk) begin
                    mon_word = {mon_word[14:0], spi_mosi};
                    mon_edges++;
                end
            end else if (mon_in) begin
                mon_word_q.push_back(mon_word);
                mon_edges_q.push_back(mon_edges);
                mon_low_q.push_back(mon_low);
                mon_in = 0;
            end
            mon_prev_sclk = spi_sclk;
        end
    end

    task automatic send_sample(input logic [31:0] un);
        int sat, rl;
        bit en;
        sat = 0;
        rl  = 0;
        @(posedge clk); #1;
        i_un    = un;
        i_valid = 1'b1;
        en      = i_enable;
        if (en) model_step(un, sat, rl);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check_eq("valid_early", o_cmd_valid, 0);
        @(posedge clk); #1;
        check_eq("valid_lat2", o_cmd_valid, en);
        check_eq("cmd", o_cmd, u16(m_cmd));
        if (en) begin
            check_eq("sat", o_sat, sat);
            check_eq("rate_lim", o_rate_lim, rl);
        end
        @(posedge clk); #1;
        check_eq("valid_pulse", o_cmd_valid, 0);
    endtask

    task automatic wait_xfer(input logic [15:0] exp_word);
        int t;
        t = 0;
        while (mon_word_q.size() == 0 && t < 600) begin
            @(posedge clk); #2;
            t++;
        end
        if (mon_word_q.size() == 0) begin
            check_eq("xfer_seen", mon_word_q.size(), 1);
        end else begin
            check_eq("dac_word", mon_word_q.pop_front(), exp_word);
            check_eq("sclk_edges", mon_edges_q.pop_front(), 16);
            check_eq("cs_low_cycles", mon_low_q.pop_front(), 33 * CLK_DIV);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (o_busy && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("busy_fall", o_busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] vals [3];
        logic [15:0] words [3];
        int sat, rl, rise_snap, iter;

        rst      = 1'b0;
        i_un     = '0;
        i_valid  = 1'b0;
        i_enable = 1'b1;
        i_min    = -16'sd32768;
        i_max    = 16'sd32767;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd", o_cmd, 0);
        check_eq("rst_valid", o_cmd_valid, 0);
        check_eq("rst_sat", o_sat, 0);
        check_eq("rst_rl", o_rate_lim, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_drop", o_drop_cnt, 0);
        check_eq("rst_cs_n", spi_cs_n, 1);
        check_eq("rst_sclk", spi_sclk, 0);
        check_eq("rst_mosi", spi_mosi, 0);
        rst = 1'b1;

        // First sample from zero is slew-limited.
        send_sample(32'h00012345);
        check_eq("t1_cmd", o_cmd, 16'h0100);
        check_eq("t1_rl", o_rate_lim, 1);
        wait_xfer(16'h8100);
        wait_idle();

        // Same sample again now lands exactly.
        send_sample(32'h00012345);
        check_eq("t2_cmd", o_cmd, 16'h0123);
        check_eq("t2_rl", o_rate_lim, 0);
        wait_xfer(16'h8123);
        wait_idle();

        // Reset in the middle of a frame.
        send_sample(32'h00005000);
        iter = 0;
        while (spi_cs_n && iter < 50) begin
            @(negedge clk);
            iter++;
        end
        check_eq("abort_frame_started", spi_cs_n, 0);
        repeat (40) @(negedge clk);
        rise_snap = total_rise;
        rst = 1'b0;
        #1;
        check_eq("abort_cs_n", spi_cs_n, 1);
        check_eq("abort_sclk", spi_sclk, 0);
        check_eq("abort_cmd", o_cmd, 0);
        check_eq("abort_busy", o_busy, 0);
        m_cmd  = 0;
        m_drop = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_eq("abort_no_sclk", total_rise - rise_snap, 0);
        check_eq("abort_no_frame", mon_word_q.size(), 0);
        check_eq("abort_cs_idle", spi_cs_n, 1);

        // Negative value from zero.
        send_sample(32'hFFFF0000);
        check_eq("neg_cmd", o_cmd, 16'hFF00);
        wait_xfer(16'h7F00);
        wait_idle();

        // Upper clamp, approached in slew-limited steps.
        i_max = 16'sh1000;
        iter  = 0;
        while (m_cmd != 4096 && iter < 40) begin
            send_sample(32'h7FFFFFFF);
            wait_xfer(dac_word(m_cmd));
            wait_idle();
            iter++;
        end
        check_eq("clamp_cmd", o_cmd, 16'h1000);
        check_eq("clamp_sat", o_sat, 1);
        i_max = 16'sd32767;

        // Three samples three cycles apart during one frame.
        vals[0] = 32'h00001000;
        vals[1] = 32'h00000000;
        vals[2] = 32'hFFF00000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            i_un    = vals[k];
            i_valid = 1'b1;
            model_step(vals[k], sat, rl);
            words[k] = dac_word(m_cmd);
            @(posedge clk); #1;
            i_valid = 1'b0;
            @(posedge clk);
        end
        m_drop = m_drop + 1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("burst_cmd", o_cmd, u16(m_cmd));
        check_eq("burst_drop", o_drop_cnt, 1);
        wait_xfer(words[0]);
        check_eq("busy_pending", o_busy, 1);
        wait_xfer(words[2]);
        check_eq("busy_gap2", o_busy, 1);
        wait_idle();
        repeat (300) @(posedge clk);
        #1;
        check_eq("no_third_xfer", mon_word_q.size(), 0);

        // Randomized samples, limits and enable.
        for (int n = 0; n < 24; n++) begin
            int a, b, sel;
            logic [31:0] un;
            i_enable = ($urandom_range(0, 4) != 0);
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                i_min = 16'sd1000;
                i_max = -16'sd1000;
            end else begin
                a = int'($urandom_range(0, 65535)) - 32768;
                b = int'($urandom_range(0, 65535)) - 32768;
                i_min = (a < b) ? a[15:0] : b[15:0];
                i_max = (a < b) ? b[15:0] : a[15:0];
            end
            sel = $urandom_range(0, 2);
            if (sel == 0)      un = $urandom;
            else if (sel == 1) un = $urandom_range(0, 32'h00FFFFFF) - 32'h00800000;
            else               un = $urandom_range(0, 32'h0003FFFF) - 32'h00020000;
            send_sample(un);
            if (i_enable) begin
                wait_xfer(dac_word(m_cmd));
                wait_idle();
            end else begin
                repeat (5) @(posedge clk);
                #1;
                check_eq("dis_busy", o_busy, 0);
            end
            check_eq("drop_hold", o_drop_cnt, m_drop);
        end
        i_enable = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
